// File: rtl/lfsr_sng_multi.sv
// Fibonacci LFSR stochastic number generator with NCH decorrelated channels.
// Each channel compares a rotated, bit-reversed LFSR slice against its probability word.
module lfsr_sng_multi #(
   parameter int unsigned      WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAPS         = 16'h8016,
   parameter int unsigned      OUT_W        = 8,
   parameter int unsigned      NCH          = 2,
   parameter int unsigned      ROT          = 5,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
   input  logic                   TRIG,
   input  logic                   RESET_n,
   input  logic                   EN,
   input  logic                   SEED_LD,
   input  logic [WIDTH-1:0]       SEED,
   input  logic [NCH*OUT_W-1:0]   P_IN,
   output logic [NCH-1:0]         SN_OUT,
   output logic [NCH*OUT_W-1:0]   RAND_OUT,
   output logic [WIDTH-1:0]       STATE,
   output logic                   RUNNING,
   output logic                   PERIOD_DONE,
   output logic                   LOCKUP
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] cnt_q;
   logic [NCH-1:0]   sn_q;
   logic [NCH-1:0]   lt;
   logic             pd_q;
   logic             lock_q;
   logic             do_load;
   logic             do_shift;
   logic             do_recover;
   logic             fb;

   assign fb = ^(lfsr_q & TAPS);

   always_comb begin
      state_d    = state_q;
      do_load    = 1'b0;
      do_shift   = 1'b0;
      do_recover = 1'b0;
      if (SEED_LD) begin
         do_load = 1'b1;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (EN) state_d = RUN;
            RUN: begin
               // all-zero state is recovered regardless of EN; FSM stays in RUN
               if (lfsr_q == '0) do_recover = 1'b1;
               else if (EN)      do_shift   = 1'b1;
               else              state_d    = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge TRIG or negedge RESET_n) begin
      if (!RESET_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge TRIG or negedge RESET_n) begin
      if (!RESET_n) begin
         lfsr_q <= DEFAULT_SEED;
         cnt_q  <= '0;
         sn_q   <= '0;
         pd_q   <= 1'b0;
         lock_q <= 1'b0;
      end else begin
         pd_q   <= 1'b0;
         lock_q <= 1'b0;
         if (do_load) begin
            lfsr_q <= (SEED == '0) ? DEFAULT_SEED : SEED;
            cnt_q  <= '0;
         end else if (do_recover) begin
            lfsr_q <= DEFAULT_SEED;
            cnt_q  <= '0;
            lock_q <= 1'b1;
         end else if (do_shift) begin
            lfsr_q <= {lfsr_q[WIDTH-2:0], fb};
            if (cnt_q == CNT_LAST) begin
               cnt_q <= '0;
               pd_q  <= 1'b1;
            end else begin
               cnt_q <= cnt_q + WIDTH'(1);
            end
         end
         if (state_d == IDLE)
            sn_q <= '0;
         else if ((state_q == RUN) && EN)
            sn_q <= lt;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      localparam int unsigned SH = (k * ROT) % WIDTH;
      logic [OUT_W-1:0] rnd;
      // rnd[j] = (D rotl SH)[OUT_W-1-j], resolved to a constant LFSR bit index
      for (genvar j = 0; j < OUT_W; j++) begin : g_rev
         localparam int unsigned SRC = (OUT_W - 1 - j + WIDTH - SH) % WIDTH;
         assign rnd[j] = lfsr_q[SRC];
      end
      assign RAND_OUT[k*OUT_W +: OUT_W] = rnd;
      assign lt[k] = (rnd < P_IN[k*OUT_W +: OUT_W]);
   end

   assign STATE       = lfsr_q;
   assign RUNNING     = (state_q == RUN);
   assign SN_OUT      = sn_q;
   assign PERIOD_DONE = pd_q;
   assign LOCKUP      = lock_q;

endmodule

// File: tb/tb_lfsr_sng_multi.sv
// Scoreboard bench for lfsr_sng_multi: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_lfsr_sng_multi;

   logic        TRIG = 1'b0;
   logic        RESET_n;
   logic        EN;
   logic        SEED_LD;
   logic [15:0] SEED;
   logic [15:0] P_IN;
   logic [1:0]  SN_OUT;
   logic [15:0] RAND_OUT;
   logic [15:0] STATE;
   logic        RUNNING;
   logic        PERIOD_DONE;
   logic        LOCKUP;

   lfsr_sng_multi #(
      .WIDTH(16), .TAPS(16'h8016), .OUT_W(8), .NCH(2), .ROT(5), .DEFAULT_SEED(16'hACE1)
   ) dut (
      .TRIG(TRIG), .RESET_n(RESET_n), .EN(EN), .SEED_LD(SEED_LD), .SEED(SEED),
      .P_IN(P_IN), .SN_OUT(SN_OUT), .RAND_OUT(RAND_OUT), .STATE(STATE),
      .RUNNING(RUNNING), .PERIOD_DONE(PERIOD_DONE), .LOCKUP(LOCKUP)
   );

   always #5 TRIG = ~TRIG;

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [15:0] st;
      logic        run;
      logic [1:0]  sn;
      logic        pd;
      logic        lk;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;

   always @(posedge TRIG) cyc <= cyc + 1;

   function automatic logic [15:0] nx(input logic [15:0] d);
      return {d[14:0], d[15] ^ d[4] ^ d[2] ^ d[1]};
   endfunction

   function automatic logic [7:0] rand_of(input logic [15:0] d, input int unsigned k);
      int unsigned s;
      logic [15:0] r;
      logic [7:0]  o;
      s = (k * 5) % 16;
      r = (d << s) | (d >> ((16 - s) % 16));
      for (int i = 0; i < 8; i++) o[i] = r[7-i];
      return o;
   endfunction

   // channel 0 probability 8'h00, channel 1 probability 8'hFF
   function automatic logic [1:0] sn_of(input logic [15:0] d);
      return {rand_of(d, 1) < 8'hFF, rand_of(d, 0) < 8'h00};
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge TRIG);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
               checks++;
               errors++;
               $display("FAIL %s missed: sampled at cyc %0d expected at %0d", e.name, cyc, e.cyc);
            end else begin
               check({e.name, ".state"}, STATE, e.st);
               check({e.name, ".running"}, {15'd0, RUNNING}, {15'd0, e.run});
               check({e.name, ".sn_out"}, {14'd0, SN_OUT}, {14'd0, e.sn});
               check({e.name, ".period_done"}, {15'd0, PERIOD_DONE}, {15'd0, e.pd});
               check({e.name, ".lockup"}, {15'd0, LOCKUP}, {15'd0, e.lk});
               check({e.name, ".rand"}, RAND_OUT, {rand_of(e.st, 1), rand_of(e.st, 0)});
            end
         end
      end
   end

   task automatic push(input int unsigned c, input string nm, input logic [15:0] st,
                       input logic run, input logic [1:0] sn, input logic pd, input logic lk);
      exp_t e;
      e.cyc = c; e.name = nm; e.st = st; e.run = run; e.sn = sn; e.pd = pd; e.lk = lk;
      q.push_back(e);
   endtask

   task automatic step(input string nm, input logic en, input logic ld, input logic [15:0] seed,
                       input logic [15:0] st, input logic run, input logic [1:0] sn,
                       input logic pd, input logic lk, input bit chk);
      EN = en; SEED_LD = ld; SEED = seed;
      if (chk) push(cyc + 1, nm, st, run, sn, pd, lk);
      @(posedge TRIG); #1;
   endtask

   initial begin
      logic [15:0] m;
      logic [15:0] prev;
      RESET_n = 1'b0; EN = 1'b0; SEED_LD = 1'b0; SEED = '0;
      P_IN = {8'hFF, 8'h00};
      push(1, "reset", 16'hACE1, 1'b0, 2'b00, 1'b0, 1'b0);
      #12 RESET_n = 1'b1;
      @(posedge TRIG); #1;

      step("seed_ld",    0, 1, 16'h0001, 16'h0001, 0, 2'b00, 0, 0, 1);
      step("enter_run",  1, 0, 16'h0000, 16'h0001, 1, 2'b00, 0, 0, 1);
      step("shift1",     1, 0, 16'h0000, 16'h0002, 1, sn_of(16'h0001), 0, 0, 1);
      step("shift2",     1, 0, 16'h0000, 16'h0005, 1, sn_of(16'h0002), 0, 0, 1);
      step("shift3",     1, 0, 16'h0000, 16'h000B, 1, sn_of(16'h0005), 0, 0, 1);
      step("shift4",     1, 0, 16'h0000, 16'h0017, 1, sn_of(16'h000B), 0, 0, 1);
      step("en_low",     0, 0, 16'h0000, 16'h0017, 0, 2'b00, 0, 0, 1);
      step("idle_hold",  0, 0, 16'h0000, 16'h0017, 0, 2'b00, 0, 0, 1);
      step("zero_seed",  1, 1, 16'h0000, 16'hACE1, 0, 2'b00, 0, 0, 1);
      step("zero_hold",  0, 0, 16'h0000, 16'hACE1, 0, 2'b00, 0, 0, 1);
      step("run_again",  1, 0, 16'h0000, 16'hACE1, 1, 2'b00, 0, 0, 1);
      step("run_shift",  1, 0, 16'h0000, nx(16'hACE1), 1, sn_of(16'hACE1), 0, 0, 1);
      step("ld_with_en", 1, 1, 16'h1234, 16'h1234, 0, 2'b00, 0, 0, 1);

      step("ld_ace1",    0, 1, 16'hACE1, 16'hACE1, 0, 2'b00, 0, 0, 1);
      step("pd_enter",   1, 0, 16'h0000, 16'hACE1, 1, 2'b00, 0, 0, 1);
      m = 16'hACE1;
      for (int unsigned n = 1; n <= 65536; n++) begin
         prev = m;
         m = nx(m);
         step("period", 1, 0, 16'h0000, (n == 65535) ? 16'hACE1 : m, 1, sn_of(prev),
              (n == 65535), 0, 1);
      end

      EN = 1'b1; SEED_LD = 1'b0;
      push(cyc + 1, "lockup", 16'hACE1, 1'b1, sn_of(16'h0000), 1'b0, 1'b1);
      @(negedge TRIG); #1;
      force dut.lfsr_q = 16'h0000;
      #1 release dut.lfsr_q;
      @(posedge TRIG); #1;
      step("post_lock",  1, 0, 16'h0000, nx(16'hACE1), 1, sn_of(16'hACE1), 0, 0, 1);

      step("pre_reset",  1, 0, 16'h0000, 16'h0000, 1, 2'b00, 0, 0, 0);
      push(cyc, "async_reset", 16'hACE1, 1'b0, 2'b00, 1'b0, 1'b0);
      #1 RESET_n = 1'b0;
      @(posedge TRIG); #1;
      push(cyc + 1, "reset_held", 16'hACE1, 1'b0, 2'b00, 1'b0, 1'b0);
      @(posedge TRIG); #1;
      RESET_n = 1'b1;
      EN = 1'b0;

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge TRIG);
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
